// File: rtl/comparch_mem_unit_if.sv
// CPU-side control and loader handshake signals for comparch_mem_unit.
// data_bus is a tri-state net and stays a plain inout port on the memory itself.
interface comparch_mem_unit_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 13
);
   logic [15:0]       addr_bus;
   logic              rd_mem;
   logic              wr_mem;
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              busy;
   logic              err_addr;
   logic [15:0]       rd_count;
   logic [15:0]       wr_count;

   modport master (
      output addr_bus, rd_mem, wr_mem, ld_valid, ld_addr, ld_data,
      input  ld_ready, busy, err_addr, rd_count, wr_count
   );

   modport slave (
      input  addr_bus, rd_mem, wr_mem, ld_valid, ld_addr, ld_data,
      output ld_ready, busy, err_addr, rd_count, wr_count
   );
endinterface

// File: rtl/comparch_mem_unit.sv
// comparch_mem_unit: 16-bit word memory behind the CPU bus, with a
// valid/ready program loader port and one-cycle tri-state read drive.
// Optional feature macro: MEM_STATS_EN (saturating read/write counters).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | bus released, loader may transfer when CPU is quiet
// S_RD_DRIVE| driving the latched read word onto data_bus this cycle
module comparch_mem_unit #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 13,
   parameter int DEPTH  = 8192
) (
   input  logic              clk,
   input  logic              reset,
   inout  wire  [DATA_W-1:0] data_bus,
   comparch_mem_unit_if.slave bus
);

   typedef enum logic {S_IDLE, S_RD_DRIVE} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_addr_q, err_addr_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_range;
   logic              rd_acc;
   logic              rd_ok;
   logic              wr_ok;
   logic              ld_ready;
   logic              drive_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // Access qualification; a read with both strobes is a conflict, not a read.
   always_comb begin
      in_range = (bus.addr_bus[15:ADDR_W] == '0);
      rd_acc   = bus.rd_mem & ~bus.wr_mem;
      rd_ok    = rd_acc & in_range;
      wr_ok    = bus.wr_mem & ~bus.rd_mem & in_range & reset;
      ld_ready = reset & ~bus.rd_mem & ~bus.wr_mem & (state_q == S_IDLE);
   end

   // Next state, read-word capture and error pulse.
   always_comb begin
      state_d    = S_IDLE;
      rdata_d    = rdata_q;
      err_addr_d = (bus.rd_mem | bus.wr_mem) & (~in_range | (bus.rd_mem & bus.wr_mem));
      case (state_q)
         S_IDLE: begin
            if (rd_acc) state_d = S_RD_DRIVE;
         end
         S_RD_DRIVE: begin
            if (rd_acc) state_d = S_RD_DRIVE;
         end
         default: state_d = S_IDLE;
      endcase
      if (rd_acc) rdata_d = rd_ok ? mem[bus.addr_bus[ADDR_W-1:0]] : '0;
   end

   // State, read register and error flag; storage is not part of reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         rdata_q    <= '0;
         err_addr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rdata_q    <= rdata_d;
         err_addr_q <= err_addr_d;
      end
   end

   // Write port arbitration; CPU wins, loader only sees ready when CPU is quiet.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = bus.addr_bus[ADDR_W-1:0];
      mem_wdata = data_bus;
      if (wr_ok) begin
         mem_we = 1'b1;
      end else if (bus.ld_valid && ld_ready) begin
         mem_we    = 1'b1;
         mem_waddr = bus.ld_addr;
         mem_wdata = bus.ld_data;
      end
   end

   // Storage array.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Never fight a CPU write that lands while the previous read is on the bus.
   assign drive_en     = (state_q == S_RD_DRIVE) & ~bus.wr_mem;
   assign data_bus     = drive_en ? rdata_q : {DATA_W{1'bz}};
   assign bus.busy     = (state_q == S_RD_DRIVE);
   assign bus.err_addr = err_addr_q;
   assign bus.ld_ready = ld_ready;

`ifdef MEM_STATS_EN
   logic [15:0] rd_count_q, rd_count_d;
   logic [15:0] wr_count_q, wr_count_d;

   // Saturating counts of accepted CPU accesses.
   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (rd_ok && (rd_count_q != 16'hFFFF)) rd_count_d = rd_count_q + 16'd1;
      if (wr_ok && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign bus.rd_count = rd_count_q;
   assign bus.wr_count = wr_count_q;
`else
   assign bus.rd_count = '0;
   assign bus.wr_count = '0;
`endif

endmodule

// File: tb/tb_comparch_mem_unit.sv
// Bench for comparch_mem_unit: directed scenarios plus a randomized run
// checked against an array model of the memory and its bus timing.
module tb_comparch_mem_unit;
   // data_bus is pulled high, so a released bus reads as all ones.
   localparam logic [15:0] FLOAT = 16'hFFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   tri1  [15:0] data_bus;
   logic        tb_drv = 1'b0;
   logic [15:0] tb_wdata = 16'h0000;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [15:0] mdl [8192];
   int          valid_q[$];
   int          mdl_rd = 0;
   int          mdl_wr = 0;

   comparch_mem_unit_if bus ();

   assign data_bus = tb_drv ? tb_wdata : 16'hzzzz;

   comparch_mem_unit dut (
      .clk      (clk),
      .reset    (reset),
      .data_bus (data_bus),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      tb_drv = 1'b0;
      #1;
   endtask

   task automatic set_idle();
      bus.rd_mem   = 1'b0;
      bus.wr_mem   = 1'b0;
      bus.addr_bus = 16'h0000;
      bus.ld_valid = 1'b0;
      bus.ld_addr  = 13'h0000;
      bus.ld_data  = 16'h0000;
      tb_drv       = 1'b0;
   endtask

   task automatic cpu_read(input logic [15:0] a);
      set_idle();
      bus.rd_mem   = 1'b1;
      bus.addr_bus = a;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
      set_idle();
      bus.wr_mem   = 1'b1;
      bus.addr_bus = a;
      tb_wdata     = d;
      tb_drv       = 1'b1;
   endtask

   task automatic test_reset();
      set_idle();
      reset = 1'b0;
      tick();
      tick();
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_tests++; if (bus.err_addr !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err_addr); end
      n_tests++; if (data_bus !== FLOAT) begin n_fail++; $display("FAIL reset_bus: got %h expected released %h", data_bus, FLOAT); end
      n_tests++; if (bus.rd_count !== 16'h0000 || bus.wr_count !== 16'h0000) begin n_fail++; $display("FAIL reset_counts: got %h/%h expected 0000/0000", bus.rd_count, bus.wr_count); end
      bus.ld_valid = 1'b1;
      #1;
      n_tests++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready: got %b expected 0", bus.ld_ready); end
      set_idle();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_loader_fill();
      logic [15:0] addrs [14];
      logic [15:0] datas [14];
      addrs[0] = 16'h0000; datas[0] = 16'h000A;
      addrs[1] = 16'h000A; datas[1] = 16'h1234;
      for (int i = 2; i < 14; i++) begin
         addrs[i] = 16'($urandom_range(16'h0100, 16'h1FFF));
         datas[i] = 16'($urandom);
      end
      set_idle();
      for (int i = 0; i < 14; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_addr  = addrs[i][12:0];
         bus.ld_data  = datas[i];
         #1;
         n_tests++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready[%0d]: got %b expected 1", i, bus.ld_ready); end
         tick();
         n_tests++; if (bus.err_addr !== 1'b0) begin n_fail++; $display("FAIL load_err[%0d]: got %b expected 0", i, bus.err_addr); end
         mdl[addrs[i]] = datas[i];
         valid_q.push_back(int'(addrs[i]));
      end
      set_idle();
   endtask

   task automatic test_single_read();
      cpu_read(16'h000A);
      tick();
      set_idle();
      n_tests++; if (data_bus !== 16'h1234) begin n_fail++; $display("FAIL single_data: got %h expected 1234", data_bus); end
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
      tick();
      n_tests++; if (data_bus !== FLOAT) begin n_fail++; $display("FAIL single_release: got %h expected released %h", data_bus, FLOAT); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_clr: got %b expected 0", bus.busy); end
   endtask

   task automatic test_write_read();
      cpu_write(16'h0010, 16'hBEEF);
      tick();
      mdl[16'h0010] = 16'hBEEF;
      valid_q.push_back(16'h0010);
      n_tests++; if (bus.err_addr !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL write_flags: got err=%b busy=%b expected 0/0", bus.err_addr, bus.busy); end
      cpu_read(16'h0010);
      tick();
      set_idle();
      n_tests++; if (data_bus !== 16'hBEEF) begin n_fail++; $display("FAIL write_read: got %h expected BEEF", data_bus); end
      tick();
   endtask

   task automatic test_back_to_back();
      int a;
      logic [15:0] exp;
      cpu_read(16'h0000);
      tick();
      n_tests++; if (data_bus !== 16'h000A) begin n_fail++; $display("FAIL b2b_first: got %h expected 000A", data_bus); end
      cpu_read(16'h000A);
      tick();
      n_tests++; if (data_bus !== 16'h1234 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %h busy=%b expected 1234 busy=1", data_bus, bus.busy); end
      for (int i = 0; i < 8; i++) begin
         a = valid_q[$urandom_range(0, valid_q.size() - 1)];
         exp = mdl[a];
         cpu_read(16'(a));
         tick();
         n_tests++; if (data_bus !== exp) begin n_fail++; $display("FAIL b2b_rand[%0d] @%h: got %h expected %h", i, a, data_bus, exp); end
      end
      set_idle();
      tick();
      n_tests++; if (data_bus !== FLOAT || bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %h busy=%b expected released, busy=0", data_bus, bus.busy); end
   endtask

   task automatic test_errors();
      logic [15:0] ld_d;
      cpu_read(16'h2000);
      tick();
      set_idle();
      n_tests++; if (bus.err_addr !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err: got %b expected 1", bus.err_addr); end
      n_tests++; if (data_bus !== 16'h0000 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL oor_rd_data: got %h busy=%b expected 0000 busy=1", data_bus, bus.busy); end
      tick();
      n_tests++; if (bus.err_addr !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse: got %b expected 0", bus.err_addr); end
      // 0x2010 aliases 0x0010 in the low bits; the write must be dropped.
      cpu_write(16'h2010, 16'h5555);
      tick();
      n_tests++; if (bus.err_addr !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b expected 1", bus.err_addr); end
      cpu_write(16'h000A, 16'hDEAD);
      bus.rd_mem = 1'b1;
      tick();
      set_idle();
      n_tests++; if (bus.err_addr !== 1'b1 || bus.busy !== 1'b0 || data_bus !== FLOAT) begin n_fail++; $display("FAIL conflict: got err=%b busy=%b bus=%h expected 1/0/%h", bus.err_addr, bus.busy, data_bus, FLOAT); end
      cpu_read(16'h0010);
      tick();
      n_tests++; if (data_bus !== 16'hBEEF) begin n_fail++; $display("FAIL oor_wr_dropped: got %h expected BEEF", data_bus); end
      cpu_read(16'h000A);
      tick();
      n_tests++; if (data_bus !== 16'h1234) begin n_fail++; $display("FAIL conflict_unchanged: got %h expected 1234", data_bus); end
      set_idle();
      tick();
      // Loader stalls behind a CPU read and its drive cycle.
      ld_d = 16'($urandom);
      cpu_read(16'h0000);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 13'h0123;
      bus.ld_data  = ld_d;
      #1;
      n_tests++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL ld_hold_rd: got %b expected 0", bus.ld_ready); end
      tick();
      bus.rd_mem = 1'b0;
      #1;
      n_tests++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL ld_hold_drive: got %b expected 0", bus.ld_ready); end
      tick();
      n_tests++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL ld_release: got %b expected 1", bus.ld_ready); end
      tick();
      mdl[16'h0123] = ld_d;
      valid_q.push_back(16'h0123);
      cpu_read(16'h0123);
      tick();
      set_idle();
      n_tests++; if (data_bus !== ld_d) begin n_fail++; $display("FAIL ld_after_stall: got %h expected %h", data_bus, ld_d); end
      tick();
   endtask

   task automatic test_reset_midread();
      cpu_read(16'h000A);
      tick();
      set_idle();
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b expected 1", bus.busy); end
      reset = 1'b0;
      tick();
      n_tests++; if (data_bus !== FLOAT || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_release: got %h busy=%b expected released, busy=0", data_bus, bus.busy); end
      reset = 1'b1;
      tick();
      cpu_read(16'h000A);
      tick();
      set_idle();
      n_tests++; if (data_bus !== 16'h1234) begin n_fail++; $display("FAIL midrst_retained: got %h expected 1234", data_bus); end
      tick();
   endtask

   task automatic test_stats();
      logic [15:0] exp_rd;
      logic [15:0] exp_wr;
      set_idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      cpu_read(16'h0000);  tick();
      cpu_read(16'h000A);  tick();
      set_idle();          tick();
      cpu_write(16'h0020, 16'h0F0F); tick();
      mdl[16'h0020] = 16'h0F0F;
      valid_q.push_back(16'h0020);
      cpu_read(16'h0020);  tick();
      cpu_read(16'h3000);  tick();
      cpu_write(16'h0020, 16'h1111); bus.rd_mem = 1'b1; tick();
      cpu_write(16'hE020, 16'h2222); tick();
      set_idle();          tick();
`ifdef MEM_STATS_EN
      exp_rd = 16'd3;
      exp_wr = 16'd1;
`else
      exp_rd = 16'd0;
      exp_wr = 16'd0;
`endif
      n_tests++; if (bus.rd_count !== exp_rd) begin n_fail++; $display("FAIL stats_rd: got %0d expected %0d", bus.rd_count, exp_rd); end
      n_tests++; if (bus.wr_count !== exp_wr) begin n_fail++; $display("FAIL stats_wr: got %0d expected %0d", bus.wr_count, exp_wr); end
   endtask

   task automatic test_random();
      int          op;
      int          a;
      logic [15:0] d;
      logic [15:0] exp_data;
      logic        exp_busy;
      logic        exp_err;
      logic        exp_rdy;
      logic        prev_rd;
      set_idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      mdl_rd  = 0;
      mdl_wr  = 0;
      prev_rd = 1'b0;
      for (int i = 0; i < 300; i++) begin
         op = int'($urandom_range(0, 9));
         set_idle();
         exp_busy = 1'b0;
         exp_err  = 1'b0;
         exp_data = FLOAT;
         case (op)
            0, 1, 2: begin
               a = valid_q[$urandom_range(0, valid_q.size() - 1)];
               cpu_read(16'(a));
               exp_busy = 1'b1;
               exp_data = mdl[a];
               mdl_rd++;
            end
            3, 4: begin
               a = int'($urandom_range(0, 8191));
               d = 16'($urandom);
               cpu_write(16'(a), d);
               mdl[a] = d;
               valid_q.push_back(a);
               mdl_wr++;
            end
            5: begin
               a = int'(($urandom_range(1, 7) << 13) | $urandom_range(0, 8191));
               cpu_read(16'(a));
               exp_busy = 1'b1;
               exp_data = 16'h0000;
               exp_err  = 1'b1;
            end
            6: begin
               a = int'(($urandom_range(1, 7) << 13) | $urandom_range(0, 8191));
               cpu_write(16'(a), 16'($urandom));
               exp_err = 1'b1;
            end
            7: begin
               a = valid_q[$urandom_range(0, valid_q.size() - 1)];
               cpu_write(16'(a), 16'($urandom));
               bus.rd_mem = 1'b1;
               exp_err = 1'b1;
            end
            8: begin
               if (!prev_rd) begin
                  a = int'($urandom_range(0, 8191));
                  d = 16'($urandom);
                  bus.ld_valid = 1'b1;
                  bus.ld_addr  = 13'(a);
                  bus.ld_data  = d;
                  mdl[a] = d;
                  valid_q.push_back(a);
               end
            end
            default: ;
         endcase
         exp_rdy = !(bus.rd_mem || bus.wr_mem) && !prev_rd;
         #1;
         n_tests++; if (bus.ld_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ld_ready[%0d] op=%0d: got %b expected %b", i, op, bus.ld_ready, exp_rdy); end
         tick();
         n_tests++; if (bus.busy !== exp_busy || bus.err_addr !== exp_err) begin n_fail++; $display("FAIL rand_flags[%0d] op=%0d: got busy=%b err=%b expected busy=%b err=%b", i, op, bus.busy, bus.err_addr, exp_busy, exp_err); end
         n_tests++; if (data_bus !== exp_data) begin n_fail++; $display("FAIL rand_data[%0d] op=%0d: got %h expected %h", i, op, data_bus, exp_data); end
         prev_rd = exp_busy;
      end
      set_idle();
      tick();
`ifdef MEM_STATS_EN
      n_tests++; if (bus.rd_count !== 16'(mdl_rd) || bus.wr_count !== 16'(mdl_wr)) begin n_fail++; $display("FAIL rand_stats: got %0d/%0d expected %0d/%0d", bus.rd_count, bus.wr_count, mdl_rd, mdl_wr); end
`else
      n_tests++; if (bus.rd_count !== 16'h0000 || bus.wr_count !== 16'h0000) begin n_fail++; $display("FAIL rand_stats: got %0d/%0d expected 0/0", bus.rd_count, bus.wr_count); end
`endif
   endtask

   initial begin
      set_idle();
      #2;
      test_reset();
      test_loader_fill();
      test_single_read();
      test_write_read();
      test_back_to_back();
      test_errors();
      test_reset_midread();
      test_stats();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/comparch_mem_unit.md
Name: comparch_mem_unit

Overview:
- Synthesizable 16-bit word memory that sits directly downstream of the 16-bit CPU.
- Serves the CPU's addr_bus / rd_mem / wr_mem / data_bus cycles and replaces the file-backed bench memory.
- Provides a valid/ready loader port so the program image (3-bit opcode in [15:13], 13-bit operand in [12:0]) is written before or between CPU runs.
- Owns the data_bus tri-state drive during reads.

Parameters:
- DATA_W, 16: word width.
- ADDR_W, 13: implemented address bits.
- DEPTH, 8192: number of words; must equal 2**ADDR_W.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- addr_bus  in  16  CPU address; bits [12:0] index memory.
- rd_mem  in  1  CPU read request, sampled each rising edge.
- wr_mem  in  1  CPU write request, sampled each rising edge.
- data_bus  inout  16  shared CPU data bus; driven only while drive_en=1, else 16'bz.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  loader may transfer this cycle.
- ld_addr  in  13  loader target address.
- ld_data  in  16  loader word.
- busy  out  1  high while in RD_DRIVE.
- err_addr  out  1  one-cycle pulse: out-of-range or conflicting access.
- rd_count  out  16  read statistics (see Optional Feature).
- wr_count  out  16  write statistics (see Optional Feature).

Behaviour:
- Reset (reset=0 at a rising edge):
  - State goes to IDLE; drive_en, busy, err_addr = 0; data_bus = Z.
  - Internal read register = 16'h0000; counters = 0.
  - Memory array contents are retained; reset never clears storage.
- FSM states: IDLE and RD_DRIVE.
  - IDLE, rd_mem=1 sampled: latch mem[addr_bus[12:0]] into rdata_q and go to RD_DRIVE.
  - RD_DRIVE: drive_en=1 and data_bus=rdata_q for exactly that one cycle.
  - RD_DRIVE, rd_mem=1 sampled again: back-to-back read; latch the new word and stay in RD_DRIVE.
  - RD_DRIVE, otherwise: return to IDLE.
- Read latency: data is valid on data_bus during the cycle after the edge that sampled rd_mem=1.
- Write: wr_mem=1 sampled at an edge writes data_bus into mem[addr_bus[12:0]] at that edge. No state change; legal in IDLE or RD_DRIVE. The bus is never driven by this block on a write cycle because writes are not reads.
- Read-after-write to the same address on the next edge returns the new data. Write-first array semantics on same-edge collisions are not required because rd/wr are exclusive.
- Out of range (addr_bus[15:13] != 0) with rd_mem or wr_mem:
  - err_addr pulses 1 on the next cycle.
  - A read returns 16'h0000 (still drives for one cycle).
  - A write is dropped.
- rd_mem=1 and wr_mem=1 together: no access, no drive, err_addr pulses; state goes to IDLE.
- Loader:
  - ld_ready = reset & !rd_mem & !wr_mem & (state==IDLE).
  - On ld_valid & ld_ready at an edge, mem[ld_addr] <= ld_data.
  - The CPU always has priority; a stalled loader holds ld_valid/ld_addr/ld_data stable until accepted.
- ld_ready is combinational and 0 while reset=0.
- A loader write and a CPU access never occur on the same edge.
- Reset mid-read: drive_en clears at the reset edge; the in-flight word is discarded and the bus floats.

Optional Feature:
- MEM_STATS_EN defined:
  - rd_count increments on every accepted CPU read; wr_count on every accepted CPU write (loader writes excluded).
  - Out-of-range, conflicting and dropped accesses are not counted.
  - Both counters saturate at 16'hFFFF and clear on reset.
- MEM_STATS_EN undefined: rd_count and wr_count are tied to 16'h0000 and no counter logic is built.

Test Plan:
- Loader fill: load 0x0000=16'h000A (LDA 0x00A), 0x000A=16'h1234 with ld_valid held; ld_ready=1 each cycle -> both words readable later, no err_addr.
- Single read: rd_mem=1, addr_bus=16'h000A for one cycle -> next cycle data_bus=16'h1234, busy=1; following cycle data_bus=Z, busy=0.
- Write then read: wr_mem=1, addr_bus=16'h0010, data_bus=16'hBEEF; next cycle rd_mem=1 at 0x0010 -> following cycle data_bus=16'hBEEF.
- Back-to-back reads of 0x0000 then 0x000A -> data_bus=16'h000A then 16'h1234 on consecutive cycles, no Z gap.
- Errors: rd_mem=1, addr_bus=16'h2000 -> err_addr pulse, data_bus=16'h0000. rd_mem=wr_mem=1 -> err_addr pulse, memory unchanged. Loader held off (ld_ready=0) while rd_mem=1.
- Reset and stats: assert reset=0 during RD_DRIVE -> data_bus=Z at that edge; 0x000A still reads 16'h1234 afterwards. With MEM_STATS_EN, after 3 reads and 1 write, rd_count=3 and wr_count=1.
